// File: rtl/line_monitor.sv
`default_nettype none
// -----------------------------------------------------------------------------
// line_monitor : synchronizes an async line and logs timestamped transitions
// Rev 1.0
// -----------------------------------------------------------------------------
module line_monitor #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            A,
  input  logic            en,
  input  logic            clr,
  input  logic            rd,
  output logic            valid,
  output logic            level,
  output logic [TS_W-1:0] stamp,
  output logic [7:0]      count,
  output logic            full,
  output logic            overflow
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  logic            s0;
  logic            s1;
  logic            last;
  logic [TS_W-1:0] ts;
  logic [TS_W:0]   mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [AW:0]     occ;
  logic            line_edge;
  logic            push;
  logic            pop;
  logic            accept;
  logic            drop;

  assign line_edge = s1 ^ last;
  assign push      = line_edge & en;
  assign valid     = (occ != '0);
  assign full      = (occ == FULL_OCC);
  assign pop       = rd & valid;
  // A full FIFO still accepts when the head leaves on the same edge
  assign accept    = push & (~full | pop);
  assign drop      = push & full & ~pop;

  assign {level, stamp} = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0   <= 1'b0;
      s1   <= 1'b0;
      last <= 1'b0;
    end else begin
      s0   <= A;
      s1   <= s0;
      last <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts <= '0;
    end else if (clr) begin
      ts <= '0;
    end else if (en) begin
      ts <= ts + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      occ      <= '0;
      count    <= 8'd0;
      overflow <= 1'b0;
    end else if (clr) begin
      wptr     <= '0;
      rptr     <= '0;
      occ      <= '0;
      count    <= 8'd0;
      overflow <= 1'b0;
    end else begin
      if (accept) wptr <= wptr + 1'b1;
      if (pop)    rptr <= rptr + 1'b1;
      case ({accept, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (push && (count != 8'hFF)) count <= count + 8'd1;
      if (drop) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: contents are only visible through valid
  always_ff @(posedge clk) begin
    if (accept) mem[wptr] <= {s1, ts};
  end

endmodule
`default_nettype wire

// File: tb/tb_line_monitor.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_line_monitor : randomized scoreboard bench for line_monitor
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_line_monitor;

  localparam int TS_W   = 4;
  localparam int DEPTH  = 4;
  localparam int TS_MOD = 1 << TS_W;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            A;
  logic            en;
  logic            clr;
  logic            rd;
  logic            valid;
  logic            level;
  logic [TS_W-1:0] stamp;
  logic [7:0]      count;
  logic            full;
  logic            overflow;

  line_monitor #(.TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (A),
    .en       (en),
    .clr      (clr),
    .rd       (rd),
    .valid    (valid),
    .level    (level),
    .stamp    (stamp),
    .count    (count),
    .full     (full),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: accepted events go into sb in order; flush_pt marks
  // entries discarded by clear or reset.
  logic [TS_W:0] sb [$];
  int flush_pt = 0;
  int occ      = 0;
  int cnt      = 0;
  int ts       = 0;
  bit ovf      = 1'b0;
  bit seen [3] = '{1'b0, 1'b0, 1'b0};  // A as sampled 3, 2 and 1 edges ago

  int errors = 0;
  int checks = 0;
  int rd_idx = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_pt = sb.size();
      occ  = 0;
      cnt  = 0;
      ts   = 0;
      ovf  = 1'b0;
      seen = '{1'b0, 1'b0, 1'b0};
    end else begin : model_step
      bit ev;
      bit popped;
      bit taken;
      ev     = (seen[1] != seen[0]);
      popped = 1'b0;
      taken  = 1'b0;
      if (clr) begin
        flush_pt = sb.size();
        occ = 0;
        cnt = 0;
        ovf = 1'b0;
        ts  = 0;
      end else begin
        popped = rd && (occ > 0);
        if (ev && en) begin
          if (cnt < 255) cnt = cnt + 1;
          if ((occ < DEPTH) || popped) begin
            sb.push_back({seen[1], TS_W'(ts)});
            taken = 1'b1;
          end else begin
            ovf = 1'b1;
          end
        end
        occ = occ - int'(popped) + int'(taken);
        if (en) ts = (ts + 1) % TS_MOD;
      end
      seen[0] = seen[1];
      seen[1] = seen[2];
      seen[2] = A;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rd_idx < flush_pt) rd_idx = flush_pt;
    chk("valid", 32'(valid), 32'(occ > 0));
    chk("full", 32'(full), 32'(occ == DEPTH));
    chk("count", 32'(count), cnt);
    chk("overflow", 32'(overflow), 32'(ovf));
    if (valid && (rd_idx < sb.size())) begin
      chk("head", 32'({level, stamp}), 32'(sb[rd_idx]));
      if (rd && !clr && rst_n) rd_idx = rd_idx + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic a_level);
    rst_n = 1'b0;
    A     = a_level;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    A     = 1'b0;
    en    = 1'b1;
    clr   = 1'b0;
    rd    = 1'b0;
    do_reset(1'b0);

    // Quiet line, then a single rise
    tick(10);
    A = 1'b1;
    tick(5);
    rd = 1'b1; tick(1); rd = 1'b0;
    tick(2);

    // Six toggles without reading: fill, then drop two
    do_reset(1'b0);
    tick(3);
    repeat (6) begin A = ~A; tick(3); end
    tick(3);
    rd = 1'b1; tick(4); rd = 1'b0;
    tick(2);

    // Full FIFO with a pop on the push edge
    clr = 1'b1; tick(1); clr = 1'b0;
    repeat (4) begin A = ~A; tick(3); end
    A = ~A;
    tick(2);
    rd = 1'b1; tick(1); rd = 1'b0;
    tick(3);
    rd = 1'b1; tick(5); rd = 1'b0;

    // Three stored events, then clear
    repeat (3) begin A = ~A; tick(3); end
    tick(2);
    clr = 1'b1; tick(1); clr = 1'b0;
    tick(3);

    // Three stored events, then reset pulse
    repeat (3) begin A = ~A; tick(3); end
    do_reset(A);
    tick(4);

    // Timestamp wrap
    do_reset(1'b0);
    tick(15);
    A = 1'b1;
    tick(5);
    rd = 1'b1; tick(2); rd = 1'b0;

    // Disabled capture, then enabled toggles
    en = 1'b0;
    repeat (4) begin A = ~A; tick(2); end
    tick(3);
    en = 1'b1;
    tick(2);
    repeat (2) begin A = ~A; tick(3); end
    rd = 1'b1; tick(3); rd = 1'b0;

    // Line high while reset releases
    do_reset(1'b1);
    tick(4);
    rd = 1'b1; tick(1); rd = 1'b0;
    tick(2);

    // Random traffic
    repeat (400) begin
      A   = A ^ ($urandom_range(0, 2) == 0);
      en  = ($urandom_range(0, 9) != 0);
      rd  = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 49) == 0);
      tick(1);
    end
    clr = 1'b0;
    rd  = 1'b0;
    en  = 1'b1;
    tick(5);
    rd = 1'b1; tick(6); rd = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
